// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the sun-riscv fetch stage.
//  INST_NOP          : instruction presented to decode when no entry is valid (addi x0,x0,0)
//  DEFAULT_RESET_PC  : PC of the first fetch after reset unless overridden
//  fetch_state_t     : RUN / HOLD state of the fetch controller
//  fetch_entry_t     : one instruction-buffer entry, {pc, inst}
package inst_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer for the fetch stage.
//  clk, rst      : clock, synchronous active-high reset
//  flush         : empties the buffer on this edge (dominates push/pop)
//  push, din     : write one 64-bit entry (ignored when full)
//  pop           : drop the head entry (ignored when empty)
//  dout          : current head entry (valid while !empty)
//  empty, full   : occupancy flags
//  count         : number of stored entries, 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [63:0]              din,
  output logic [63:0]              dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is read combinationally so decode sees the entry in the cycle it becomes valid.
  assign dout    = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage has no reset; stale contents are never visible because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues word reads to instruction memory, buffers the
// returned words and presents {pc, inst} to decode over valid/ready.
//  clk, rst                 : clock, synchronous active-high reset
//  imem_req/addr/gnt        : request channel; address held until granted
//  imem_rvalid/rdata        : in-order read responses
//  redirect_valid/pc        : taken branch/jump/exception target (one-cycle pulse)
//  out_valid/ready/pc/inst  : decode handshake; out_inst is INST_NOP when idle
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] discard_reg;
  fetch_state_t  state_reg;
  fetch_state_t  state_next;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [63:0]   fifo_dout;
  fetch_entry_t  head;

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   inflight;
  logic [CW-1:0] issue_inc;
  logic [CW-1:0] rsp_dec;
  logic [31:0]   redirect_target;

  // Buffered plus outstanding never exceeds FIFO_DEPTH, so every response has a slot.
  // This sum cannot grow while a request waits for grant, so the request stays up.
  assign inflight        = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign imem_req        = ~rst & ~redirect_valid & (inflight < DEPTH_W);
  assign imem_addr       = fetch_pc_reg;
  assign issue           = imem_req & imem_gnt;
  assign push            = imem_rvalid & (discard_reg == '0) & ~redirect_valid & ~rst;
  assign pop             = out_valid & out_ready;
  assign issue_inc       = {{(CW-1){1'b0}}, issue};
  assign rsp_dec         = {{(CW-1){1'b0}}, imem_rvalid};
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign head      = fetch_entry_t'(fifo_dout);
  assign out_valid = ~fifo_empty;
  assign out_pc    = out_valid ? head.pc   : 32'h0;
  assign out_inst  = out_valid ? head.inst : INST_NOP;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({rsp_pc_reg, imem_rdata}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else if (redirect_valid) begin
      // No issue happens in a redirect cycle; everything still in flight becomes
      // junk, minus a response landing this very cycle (it is dropped here).
      fetch_pc_reg    <= redirect_target;
      rsp_pc_reg      <= redirect_target;
      outstanding_reg <= outstanding_reg - rsp_dec;
      discard_reg     <= outstanding_reg - rsp_dec;
    end else begin
      if (issue) fetch_pc_reg <= fetch_pc_reg + 32'd4;
      if (push)  rsp_pc_reg   <= rsp_pc_reg + 32'd4;
      outstanding_reg <= outstanding_reg + issue_inc - rsp_dec;
      if (imem_rvalid && (discard_reg != '0)) discard_reg <= discard_reg - 1'b1;
    end
  end

  // HOLD marks a full buffer that decode is not draining; outputs do not depend on it.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= FETCH_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_RUN:  if (fifo_full && !out_ready && !redirect_valid) state_next = FETCH_HOLD;
      FETCH_HOLD: if (pop || redirect_valid)                      state_next = FETCH_RUN;
      default:    state_next = FETCH_RUN;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by a random-stall
// phase. A memory model answers requests in order with programmable latency; a
// monitor pops the expected {pc, inst} queue whenever decode accepts an entry.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  inst_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_rsp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          issue_cnt = 0;
  int          pop_cnt = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  mem_rsp_t    mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_fetch_pc = RESET_PC;
  logic        prev_req_pending = 1'b0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: one in-order response per cycle once its due cycle arrives.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    #2;
    if (rst) begin
      mem_q.delete();
      imem_rvalid = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Monitor / scoreboard, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      exp_fetch_pc     = RESET_PC;
      prev_req_pending = 1'b0;
    end else begin
      if (!out_valid) chk("idle_inst", out_inst, INST_NOP);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %h, required no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", out_inst, e.inst);
          pop_cnt++;
          $display("pop pc=%h inst=%h", out_pc, out_inst);
        end
      end
      if (prev_req_pending && !redirect_valid) chk("req_held", {31'b0, imem_req}, 32'd1);
      if (redirect_valid) begin
        chk("req_in_redirect", {31'b0, imem_req}, 32'd0);
        exp_q.delete();
        exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (imem_req && imem_gnt) begin
        chk("imem_addr", imem_addr, exp_fetch_pc);
        mem_q.push_back('{data: mem_fn(imem_addr), due: cyc + int'($urandom_range(lat_max, lat_min))});
        exp_q.push_back('{pc: exp_fetch_pc, inst: mem_fn(exp_fetch_pc)});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        issue_cnt++;
      end
      prev_req_pending = imem_req && !imem_gnt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int  issue_start;
    bit  found;
    rst = 1'b1;
    imem_gnt = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, INST_NOP);
    chk("rst_addr", imem_addr, RESET_PC);

    // 1: stream at memory latency 1; first entry two cycles after the first issue.
    tick; rst = 1'b0;
    @(negedge clk);
    chk("t1_valid_c0", {31'b0, out_valid}, 32'd0);
    chk("t1_req_c0", {31'b0, imem_req}, 32'd1);
    chk("t1_addr_c0", imem_addr, 32'h0);
    tick; @(negedge clk);
    chk("t1_valid_c1", {31'b0, out_valid}, 32'd0);
    chk("t1_addr_c1", imem_addr, 32'h4);
    tick; @(negedge clk);
    chk("t1_valid_c2", {31'b0, out_valid}, 32'd1);
    chk("t1_pc_c2", out_pc, 32'h0);
    repeat (10) tick;

    // 6: fill the buffer, then reset mid-stream.
    out_ready = 1'b0;
    repeat (5) tick;
    @(negedge clk);
    chk("t6_full_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_full_req", {31'b0, imem_req}, 32'd0);
    tick; rst = 1'b1;
    tick; rst = 1'b0;
    issue_start = issue_cnt;
    @(negedge clk);
    chk("t6_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_addr", imem_addr, RESET_PC);

    // 2: decode stalled for 10 cycles after reset: exactly two issues, buffer holds 0,4.
    repeat (9) tick;
    @(negedge clk); #1;
    chk("t2_issues", issue_cnt - issue_start, 32'd2);
    chk("t2_req", {31'b0, imem_req}, 32'd0);
    chk("t2_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_head_pc", out_pc, 32'h0);
    tick; out_ready = 1'b1;
    repeat (10) tick;

    // 3: redirect to 0x100 with two requests outstanding.
    lat_min = 3; lat_max = 3;
    tick; rst = 1'b1;
    tick; rst = 1'b0;
    tick;
    tick; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_valid", {31'b0, out_valid}, 32'd0);
    chk("t3_addr", imem_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick; @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    chk("t3_seen", {31'b0, found}, 32'd1);
    chk("t3_first_pc", out_pc, 32'h0000_0100);
    repeat (8) tick;

    // 4: unaligned redirect target is word-aligned.
    lat_min = 1; lat_max = 1;
    tick; redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_addr", imem_addr, 32'h0000_0200);
    chk("t4_valid", {31'b0, out_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick; @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    chk("t4_seen", {31'b0, found}, 32'd1);
    chk("t4_first_pc", out_pc, 32'h0000_0200);

    // 5: redirect in the same cycle as a response and a pop.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick; #2;
      if (imem_rvalid && out_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        found          = 1'b1;
      end
    end
    chk("t5_found", {31'b0, found}, 32'd1);
    tick; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_addr", imem_addr, 32'h0000_0300);
    repeat (6) tick;

    // Random stalls, latencies 1-4, occasional redirects.
    lat_min = 1; lat_max = 4;
    pop_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      tick;
      imem_gnt       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom & 32'h0000_0FFF;
    end
    tick;
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    out_ready = 1'b1;
    repeat (20) tick;
    @(negedge clk); #1;
    checks++;
    if (pop_cnt < 150) begin
      errors++;
      $display("FAIL random_progress: got %0d pops, required at least 150", pop_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
